// File: rtl/splinker_actuator_pkg.sv
// Shared definitions for the sprinkler actuator: state codes, interlock bit
// positions and small helpers used by the FSM and the debounce filters.
package splinker_actuator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPENING  = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_CLOSING  = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam int unsigned IL_WATER_BIT  = 0;
  localparam int unsigned IL_SENSOR_BIT = 1;
  localparam int unsigned IL_W          = 2;

  localparam int unsigned      RUN_CNT_W     = 16;
  localparam logic [RUN_CNT_W-1:0] RUN_COUNT_MAX = 16'hFFFF;

  function automatic int unsigned deb_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [RUN_CNT_W-1:0] sat_inc_run(input logic [RUN_CNT_W-1:0] v);
    return (v == RUN_COUNT_MAX) ? v : v + 16'd1;
  endfunction

  function automatic logic is_timed(input state_e s);
    return (s == ST_OPENING) || (s == ST_RUNNING) ||
           (s == ST_CLOSING) || (s == ST_COOLDOWN);
  endfunction

  function automatic logic valve_for(input state_e s);
    return (s == ST_OPENING) || (s == ST_RUNNING) || (s == ST_CLOSING);
  endfunction

  function automatic logic pump_for(input state_e s);
    return s == ST_RUNNING;
  endfunction

endpackage

// File: rtl/splinker_actuator_sync_debounce.sv
// Level filter: q follows d only after d has differed from q on N
// consecutive rising edges; any edge where d matches q restarts the count.
module sync_debounce
  import splinker_actuator_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int unsigned    CW   = deb_cnt_w(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (d != q_q) begin
      if (cnt_q == LAST) begin
        q_d = d;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/splinker_actuator.sv
// Valve/pump sequencer for the sprinkler request: debounced request, valve
// lead/lag around the pump, minimum on/off windows and a hard supply interlock.
module splinker_actuator
  import splinker_actuator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 4,
  parameter int unsigned VALVE_LEAD_CYCLES = 3,
  parameter int unsigned MIN_ON_CYCLES     = 50,
  parameter int unsigned MIN_OFF_CYCLES    = 20,
  parameter int unsigned CNT_W             = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        splinker_bomb,
  input  logic        water_critical,
  input  logic        sensor_error,
  output logic        valve_open,
  output logic        pump_on,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] run_count
);

  localparam logic [CNT_W-1:0] LEAD_LAST    = CNT_W'(VALVE_LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [RUN_CNT_W-1:0] run_count_q, run_count_d;
  logic                 valve_open_q, valve_open_d;
  logic                 pump_on_q, pump_on_d;
  logic                 fault_q, fault_d;

  logic [IL_W-1:0] il_vec;
  logic            interlock;
  logic            clr_rst;
  logic            req_filt;
  logic            il_clear;

  assign il_vec[IL_WATER_BIT]  = water_critical;
  assign il_vec[IL_SENSOR_BIT] = sensor_error;
  assign interlock             = |il_vec;

  // The clear filter is held in reset while the interlock is active, so its
  // output only rises after a full run of clean samples.
  assign clr_rst = reset | interlock;

  sync_debounce #(.N(DEBOUNCE_CYCLES)) u_req_deb (
    .clock (clock),
    .reset (reset),
    .d     (splinker_bomb),
    .q     (req_filt)
  );

  sync_debounce #(.N(DEBOUNCE_CYCLES)) u_clr_deb (
    .clock (clock),
    .reset (clr_rst),
    .d     (~interlock),
    .q     (il_clear)
  );

  always_comb begin
    state_d = state_q;
    if (interlock) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:     if (req_filt) state_d = ST_OPENING;
        ST_OPENING: begin
          if (!req_filt)                 state_d = ST_COOLDOWN;
          else if (timer_q == LEAD_LAST) state_d = ST_RUNNING;
        end
        ST_RUNNING:  if (!req_filt && (timer_q >= MIN_ON_LAST)) state_d = ST_CLOSING;
        ST_CLOSING:  if (timer_q == LEAD_LAST) state_d = ST_COOLDOWN;
        ST_COOLDOWN: if (timer_q == MIN_OFF_LAST) state_d = ST_IDLE;
        ST_FAULT:    if (il_clear) state_d = ST_COOLDOWN;
        default:     state_d = ST_FAULT;
      endcase
    end
  end

  // Timer restarts on every state change and sticks at all-ones.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (is_timed(state_q) && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  always_comb begin
    run_count_d = run_count_q;
    if ((state_q == ST_RUNNING) && (state_d != ST_RUNNING)) begin
      run_count_d = sat_inc_run(run_count_q);
    end
  end

  // Drives are decoded from the next state into flops so they change
  // together with the state register and never glitch.
  always_comb begin
    valve_open_d = valve_for(state_d);
    pump_on_d    = pump_for(state_d);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      run_count_q  <= '0;
      valve_open_q <= 1'b0;
      pump_on_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      run_count_q  <= run_count_d;
      valve_open_q <= valve_open_d;
      pump_on_q    <= pump_on_d;
      fault_q      <= fault_d;
    end
  end

  assign valve_open = valve_open_q;
  assign pump_on    = pump_on_q;
  assign fault      = fault_q;
  assign state      = state_q;
  assign run_count  = run_count_q;

endmodule

// File: tb/tb_splinker_actuator.sv
// Bench for splinker_actuator: directed vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a behavioural model.
module tb_splinker_actuator;

  localparam int DEB    = 2;
  localparam int LEAD   = 2;
  localparam int MINON  = 5;
  localparam int MINOFF = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        splinker_bomb;
  logic        water_critical;
  logic        sensor_error;
  logic        valve_open;
  logic        pump_on;
  logic        fault;
  logic [2:0]  state;
  logic [15:0] run_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  splinker_actuator #(
    .DEBOUNCE_CYCLES   (DEB),
    .VALVE_LEAD_CYCLES (LEAD),
    .MIN_ON_CYCLES     (MINON),
    .MIN_OFF_CYCLES    (MINOFF),
    .CNT_W             (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .splinker_bomb  (splinker_bomb),
    .water_critical (water_critical),
    .sensor_error   (sensor_error),
    .valve_open     (valve_open),
    .pump_on        (pump_on),
    .fault          (fault),
    .state          (state),
    .run_count      (run_count)
  );

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_OPEN = 1, M_RUN = 2, M_CLOSE = 3, M_COOL = 4, M_FAULT = 5;
  bit vlut [6] = '{0, 1, 1, 1, 0, 0};
  bit plut [6] = '{0, 0, 1, 0, 0, 0};
  bit flut [6] = '{0, 0, 0, 0, 0, 1};

  int m_state  = 0;
  int m_time   = 0;
  int m_rc     = 0;
  int m_lowrun = 0;
  bit m_filt   = 0;
  bit hist[$];

  task automatic model_step(input bit r, input bit b, input bit w, input bit s);
    int  nxt;
    bit  il;
    bit  clr;
    bit  all_same;
    if (r) begin
      m_state = M_IDLE; m_time = 0; m_rc = 0; m_lowrun = 0; m_filt = 0;
      hist.delete();
      return;
    end
    il  = w | s;
    clr = (m_lowrun >= DEB);
    nxt = m_state;
    if (il) nxt = M_FAULT;
    else begin
      case (m_state)
        M_IDLE:  if (m_filt) nxt = M_OPEN;
        M_OPEN:  if (!m_filt) nxt = M_COOL; else if (m_time == LEAD - 1) nxt = M_RUN;
        M_RUN:   if (!m_filt && m_time >= MINON - 1) nxt = M_CLOSE;
        M_CLOSE: if (m_time == LEAD - 1) nxt = M_COOL;
        M_COOL:  if (m_time == MINOFF - 1) nxt = M_IDLE;
        default: if (clr) nxt = M_COOL;
      endcase
    end
    if (m_state == M_RUN && nxt != M_RUN && m_rc < 65535) m_rc++;
    m_time  = (nxt != m_state) ? 0 : m_time + 1;
    m_state = nxt;
    // request filter: adopt a value once the last DEB raw samples all agree on it
    hist.push_back(b);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != b) all_same = 0;
    if (all_same && b != m_filt) m_filt = b;
    m_lowrun = il ? 0 : ((m_lowrun < 1000) ? m_lowrun + 1 : m_lowrun);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [2:0] st, input logic v, input logic p,
                                       input logic f, input logic [15:0] rc);
    return {10'd0, st, v, p, f, rc};
  endfunction

  task automatic tick(input bit r, input bit b, input bit w, input bit s);
    reset = r; splinker_bomb = b; water_critical = w; sensor_error = s;
    @(posedge clock);
    model_step(r, b, w, s);
    #1;
    check("model", pack(state, valve_open, pump_on, fault, run_count),
          pack(3'(m_state), vlut[m_state], plut[m_state], flut[m_state], 16'(m_rc)));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r, b, w, s;
    logic [2:0]  st;
    bit          v, p, f;
    logic [15:0] rc;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit r, input bit b, input bit w, input bit s,
                     input int st, input bit v, input bit p, input bit f, input int rc);
    vec_t e;
    e.r = r; e.b = b; e.w = w; e.s = s;
    e.st = 3'(st); e.v = v; e.p = p; e.f = f; e.rc = 16'(rc);
    vt.push_back(e);
  endtask

  bit rb, rr, rw, rs, held;

  initial begin
    reset = 1'b1; splinker_bomb = 1'b0; water_critical = 1'b0; sensor_error = 1'b0;

    // edges 1-16: start, early drop held until MIN_ON, closing, cooldown
    for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, (i < 3) ? 0 : (i < 5) ? 1 : 2, i >= 3, i >= 5, 0, 0);
    for (int i = 6; i <= 9; i++) add(0, 0, 0, 0, 2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 3, 1, 0, 0, 1);
    add(0, 0, 0, 0, 3, 1, 0, 0, 1);
    for (int i = 12; i <= 15; i++) add(0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // edges 17-32: restart, water_critical pulse in RUNNING, recovery and restart
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 2, 1, 1, 0, 1);
    add(0, 1, 1, 0, 5, 0, 0, 1, 2);
    add(0, 1, 0, 0, 5, 0, 0, 1, 2);
    add(0, 1, 0, 0, 5, 0, 0, 1, 2);
    for (int i = 25; i <= 28; i++) add(0, 1, 0, 0, 4, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 1, 1, 0, 0, 2);
    add(0, 1, 0, 0, 1, 1, 0, 0, 2);
    add(0, 1, 0, 0, 2, 1, 1, 0, 2);
    // edges 33-34: reset while RUNNING
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);

    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("reset_state", pack(state, valve_open, pump_on, fault, run_count), 32'd0);

    foreach (vt[i]) begin
      tick(vt[i].r, vt[i].b, vt[i].w, vt[i].s);
      check($sformatf("vec[%0d]", i + 1), pack(state, valve_open, pump_on, fault, run_count),
            pack(vt[i].st, vt[i].v, vt[i].p, vt[i].f, vt[i].rc));
    end

    // one-cycle request glitches never pass the filter
    tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(0, (i % 2) == 0, 0, 0);
      check("glitch_valve", {31'd0, valve_open}, 32'd0);
      check("glitch_filt", {31'd0, dut.req_filt}, 32'd0);
    end

    // sensor_error interlock during OPENING, then recovery
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    check("open_before_il", {29'd0, state}, 32'd1);
    tick(0, 1, 0, 1);
    check("sensor_fault", pack(state, valve_open, pump_on, fault, 16'd0), pack(3'd5, 0, 0, 1, 16'd0));
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    check("fault_exit", {29'd0, state}, 32'd4);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);

    // saturated run counter survives another completed run
    force dut.run_count_q = 16'hFFFF;
    m_rc = 65535;
    tick(0, 0, 0, 0);
    release dut.run_count_q;
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0);
    check("sat_running", {29'd0, state}, 32'd2);
    for (int i = 0; i < 16; i++) tick(0, 0, 0, 0);
    check("sat_count", {16'd0, run_count}, 32'h0000FFFF);
    check("sat_idle", {29'd0, state}, 32'd0);

    // randomized stimulus against the model
    tick(1, 0, 0, 0);
    held = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) held = ~held;
      rb = held;
      if ($urandom_range(0, 15) == 0) rb = ~held;
      rw = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 79) == 0);
      rr = ($urandom_range(0, 399) == 0);
      tick(rr, rb, rw, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
